data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Data-memory responder at the far end of the M-stage memory interface.
//  Serves combinational word reads and byte-enabled synchronous writes on the
//  same cycle the M stage presents an access.
//  Registers a one-cycle write-trace record (PC, word address, merged word) for the bench.
//  Keeps a sticky error flag for out-of-range accesses.
// PARAMETERS
//  ADDR_W   12           word-index width; memory depth = 2**ADDR_W words
//  BASE     32'h0000_0000 byte address of word 0
// PORTS
//  clk          in   1   pipeline clock, rising edge
//  reset        in   1   asynchronous, active-high
//  a_PCM        in   32  PC of the instruction in M (trace only)
//  a_MEM        in   32  byte address from M stage
//  v_MEM_wdata  in   32  lane-replicated store data
//  c_byte       in   4   byte write enables; bit i -> bits [8i+7:8i]; 0 = no write
//  v_MEM_rdata  out  32  word at a_MEM (combinational)
//  wr_valid     out  1   trace record valid (one cycle per committed write)
//  wr_pc        out  32  PC of the committed write
//  wr_addr      out  32  word-aligned byte address written ({a_MEM[31:2],2'b00})
//  wr_data      out  32  full word contents after the merge
//  err          out  1   sticky out-of-range flag
// BEHAVIOUR
//  - Reset (async): all 2**ADDR_W words <= 0.
//    wr_valid, wr_pc, wr_addr, wr_data, err <= 0.
//    v_MEM_rdata then reads 0 for every in-range address.
//  - Address decode:
//    off = a_MEM - BASE.
//    in_range = (off < 4*2**ADDR_W).
//    idx = off[ADDR_W+1:2]; the low two bits are ignored (aligned word select).
//  - Read: v_MEM_rdata = in_range ? mem[idx] : 32'h0.
//    Zero latency.
//    Lane extraction and sign extension are done by the requester, not here.
//  - Write: on posedge clk when c_byte != 0 and in_range.
//    Per lane i: mem[idx][8i+7:8i] <= c_byte[i] ? v_MEM_wdata[8i+7:8i] : old lane.
//    Enabled lanes are used as given; the data is not shifted.
//  - Read-during-write, same word: v_MEM_rdata shows the old word during that cycle.
//    The new word is visible from the next cycle.
//  - Trace: on the same edge as a committed write:
//    wr_valid <= 1, wr_pc <= a_PCM, wr_addr <= aligned address, wr_data <= merged word.
//    Otherwise wr_valid <= 0; wr_pc, wr_addr and wr_data hold their values.
//  - c_byte == 0: no write and no trace; err is not affected.
//  - Out of range:
//    Write attempt (c_byte != 0): memory unchanged, wr_valid <= 0, err <= 1.
//    Read: returns 0 and does not set err.
//  - err stays set until reset.
//  - Reset asserted mid-write: reset wins. The memory is cleared and no trace is emitted.
//  - Back-to-back writes to the same word merge cumulatively.
//    Each write produces its own trace record.
// TESTING
//  1. Reset, then read 0x0000, 0x3FFC -> rdata 0; wr_valid=0, err=0.
//  2. sw: a=0x10, wdata=0xDEADBEEF, c_byte=4'b1111
//     -> next cycle wr_valid=1, wr_addr=0x10, wr_data=0xDEADBEEF; rdata@0x10=0xDEADBEEF.
//  3. sb: a=0x11, wdata=0x55555555, c_byte=4'b0010 on word 0xDEADBEEF
//     -> wr_data=0xDEAD55EF.
//     sh: a=0x12, wdata=0x12341234, c_byte=4'b1100 -> wr_data=0x123455EF.
//  4. Same-cycle read/write of 0x20 (old 0), wdata=0xA5A5A5A5, c_byte=4'b1111
//     -> rdata=0 that cycle, 0xA5A5A5A5 the next.
//  5. Write to a=0x4000 with c_byte=4'b1111 (ADDR_W=12)
//     -> err=1 and stays 1, no trace, mem unchanged; read at 0x4000 -> 0.
//  6. Assert reset between two stores
//     -> all outputs 0 asynchronously; a prior store to 0x10 reads 0 after release.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: combinational word read, byte-enabled synchronous write, one-cycle write trace, sticky range error.
// Read is zero latency, write and trace land on the next rising edge; always ready, no backpressure.
module data_mem_responder #(
  parameter int          ADDR_W = 12,
  parameter logic [31:0] BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a_PCM,
  input  logic [31:0] a_MEM,
  input  logic [31:0] v_MEM_wdata,
  input  logic [3:0]  c_byte,
  output logic [31:0] v_MEM_rdata,
  output logic        wr_valid,
  output logic [31:0] wr_pc,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        err
);

  localparam int          DEPTH = 1 << ADDR_W;
  localparam logic [31:0] SPAN  = 32'(4 * DEPTH);

  logic [31:0]       mem [DEPTH];
  logic [31:0]       off;
  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       old_word;
  logic [31:0]       merged;
  logic              wr_en;
  logic              oor_wr;

  assign off      = a_MEM - BASE;
  assign in_range = (off < SPAN);
  assign idx      = off[ADDR_W+1:2];
  assign old_word = mem[idx];

  // Read path sees the pre-write word; a same-cycle store becomes visible next cycle.
  assign v_MEM_rdata = in_range ? old_word : 32'h0;

  assign wr_en  = in_range && (c_byte != 4'b0000);
  assign oor_wr = !in_range && (c_byte != 4'b0000);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (c_byte[i]) merged[8*i +: 8] = v_MEM_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (wr_en) begin
      mem[idx] <= merged;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_valid <= 1'b0;
      wr_pc    <= 32'h0;
      wr_addr  <= 32'h0;
      wr_data  <= 32'h0;
    end else begin
      wr_valid <= wr_en;
      if (wr_en) begin
        wr_pc   <= a_PCM;
        wr_addr <= {a_MEM[31:2], 2'b00};
        wr_data <= merged;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       err <= 1'b0;
    else if (oor_wr) err <= 1'b1;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a queue of expected write-trace records.
module tb_data_mem_responder;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a_PCM = '0;
  logic [31:0] a_MEM = '0;
  logic [31:0] v_MEM_wdata = '0;
  logic [3:0]  c_byte = '0;
  logic [31:0] v_MEM_rdata;
  logic        wr_valid;
  logic [31:0] wr_pc;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        err;

  trace_t      exp_q[$];
  trace_t      got;
  logic [31:0] model [0:4095];
  logic        exp_err = 1'b0;
  int          checks = 0;
  int          failures = 0;

  data_mem_responder #(.ADDR_W(12), .BASE(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .a_PCM       (a_PCM),
    .a_MEM       (a_MEM),
    .v_MEM_wdata (v_MEM_wdata),
    .c_byte      (c_byte),
    .v_MEM_rdata (v_MEM_rdata),
    .wr_valid    (wr_valid),
    .wr_pc       (wr_pc),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input logic [31:0] a);
    return a < 32'h0000_4000;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return in_rng(a) ? model[a[13:2]] : 32'h0;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4096; i++) model[i] = 32'h0;
  endtask

  task automatic idle();
    c_byte = 4'b0000;
    @(posedge clk);
    #1;
  endtask

  // One access cycle: checks the pre-write read, queues the expected trace, commits the model after the edge.
  task automatic cyc(input logic [31:0] pc, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] nw;
    a_PCM = pc;
    a_MEM = a;
    v_MEM_wdata = wd;
    c_byte = be;
    #1;
    chk("rdata_in_cycle", v_MEM_rdata, model_rd(a));
    nw = model_rd(a);
    for (int i = 0; i < 4; i++) if (be[i]) nw[8*i +: 8] = wd[8*i +: 8];
    if (be != 4'b0000 && in_rng(a)) exp_q.push_back('{pc: pc, addr: {a[31:2], 2'b00}, data: nw});
    @(posedge clk);
    #1;
    if (be != 4'b0000) begin
      if (in_rng(a)) model[a[13:2]] = nw;
      else           exp_err = 1'b1;
    end
    c_byte = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    c_byte = 4'b0000;
    a_MEM = a;
    #1;
    chk(tag, v_MEM_rdata, exp);
  endtask

  // Trace records are popped and compared whenever the DUT emits one.
  always @(negedge clk) begin
    if (wr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_trace observed=pc %h addr %h data %h expected=no record", wr_pc, wr_addr, wr_data);
      end else begin
        got = exp_q.pop_front();
        chk("trace_pc", wr_pc, got.pc);
        chk("trace_addr", wr_addr, got.addr);
        chk("trace_data", wr_data, got.data);
      end
    end
    chk("err_flag", 32'(err), 32'(exp_err));
  end

  initial begin
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    chk("rst_wr_valid", 32'(wr_valid), 32'h0);
    chk("rst_wr_pc", wr_pc, 32'h0);
    chk("rst_wr_addr", wr_addr, 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    rd(32'h0000_0000, 32'h0, "rst_rd_0000");
    rd(32'h0000_3FFC, 32'h0, "rst_rd_3ffc");
    rd(32'h0000_8000, 32'h0, "oor_read_zero");
    idle();
    idle();
    chk("oor_read_no_err", 32'(err), 32'h0);

    // Full-word store
    cyc(32'h0000_0100, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
    chk("sw_wr_valid", 32'(wr_valid), 32'h1);
    rd(32'h0000_0010, 32'hDEAD_BEEF, "sw_readback");

    // Byte and halfword stores merging into the same word
    cyc(32'h0000_0104, 32'h0000_0011, 32'h5555_5555, 4'b0010);
    rd(32'h0000_0010, 32'hDEAD_55EF, "sb_readback");
    cyc(32'h0000_0108, 32'h0000_0012, 32'h1234_1234, 4'b1100);
    rd(32'h0000_0010, 32'h1234_55EF, "sh_readback");

    // Back-to-back stores to one word, each with its own trace
    cyc(32'h0000_010C, 32'h0000_0014, 32'h0000_00AA, 4'b0001);
    cyc(32'h0000_0110, 32'h0000_0016, 32'h0000_BB00, 4'b0010);
    rd(32'h0000_0014, 32'h0000_BBAA, "b2b_readback");
    idle();

    // Read-during-write: old word this cycle, new word next
    cyc(32'h0000_0120, 32'h0000_0020, 32'hA5A5_A5A5, 4'b1111);
    rd(32'h0000_0020, 32'hA5A5_A5A5, "rdw_next_cycle");

    // No enables: no write, no trace
    cyc(32'h0000_0124, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0000);
    rd(32'h0000_0020, 32'hA5A5_A5A5, "no_be_unchanged");
    idle();

    // Out-of-range store
    cyc(32'h0000_0130, 32'h0000_4000, 32'hFFFF_FFFF, 4'b1111);
    chk("oor_err_set", 32'(err), 32'h1);
    chk("oor_no_trace", 32'(wr_valid), 32'h0);
    rd(32'h0000_4000, 32'h0, "oor_rd_zero");
    rd(32'h0000_0000, 32'h0, "oor_word0_unchanged");
    idle();
    idle();
    chk("oor_err_sticky", 32'(err), 32'h1);

    // Reset between two stores
    cyc(32'h0000_0140, 32'h0000_0010, 32'h1111_1111, 4'b1111);
    idle();
    a_PCM = 32'h0000_0144;
    a_MEM = 32'h0000_0030;
    v_MEM_wdata = 32'h7777_7777;
    c_byte = 4'b1111;
    #1;
    reset = 1'b1;
    exp_err = 1'b0;
    clear_model();
    #1;
    chk("arst_wr_valid", 32'(wr_valid), 32'h0);
    chk("arst_wr_pc", wr_pc, 32'h0);
    chk("arst_wr_addr", wr_addr, 32'h0);
    chk("arst_wr_data", wr_data, 32'h0);
    chk("arst_err", 32'(err), 32'h0);
    chk("arst_rdata", v_MEM_rdata, 32'h0);
    @(posedge clk);
    #1;
    c_byte = 4'b0000;
    reset = 1'b0;
    rd(32'h0000_0010, 32'h0, "arst_rd_0010");
    rd(32'h0000_0030, 32'h0, "arst_rd_0030");
    idle();
    chk("arst_no_trace", 32'(wr_valid), 32'h0);
    idle();
    chk("pending_traces", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
